// File: rtl/rbm_vote_classifier_pkg.sv
// rtl/rbm_vote_classifier_pkg.sv - shared state encoding and width helper for the vote classifier
package rbm_vote_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_ACCUM = 3'd3,
        ST_SCAN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rbm_vote_classifier_vote_argmax.sv
// rtl/rbm_vote_classifier_vote_argmax.sv - sequential argmax over the per-class vote counters
module vote_argmax #(
    parameter int class_num       = 10,
    parameter int count_bitlength = 5,
    parameter int index_bitlength = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 i_start,
    input  logic [class_num*count_bitlength-1:0] i_counts,
    output logic [index_bitlength-1:0]           o_best_idx,
    output logic                                 o_done
);

    localparam logic [index_bitlength-1:0] LAST_IDX = index_bitlength'(class_num - 1);

    logic [count_bitlength-1:0] w_count [class_num];
    logic [count_bitlength-1:0] w_cur_cnt;
    logic                       w_take;

    logic                       r_active;
    logic [index_bitlength-1:0] r_idx;
    logic [index_bitlength-1:0] r_best_idx;
    logic [count_bitlength-1:0] r_best_cnt;

    for (genvar g = 0; g < class_num; g++) begin : g_unpack
        assign w_count[g] = i_counts[g*count_bitlength +: count_bitlength];
    end

    // Index 0 seeds the running best; later indices win only on a strictly larger count.
    assign w_cur_cnt  = w_count[r_idx];
    assign w_take     = (r_idx == '0) || (w_cur_cnt > r_best_cnt);
    assign o_best_idx = w_take ? r_idx : r_best_idx;
    assign o_done     = r_active && (r_idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active   <= 1'b0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            if (w_take) begin
                r_best_idx <= r_idx;
                r_best_cnt <= w_cur_cnt;
            end
            if (o_done) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbm_vote_classifier.sv
// rtl/rbm_vote_classifier.sv - re-runs the class layer, tallies stochastic votes and reports the winner
module rbm_vote_classifier
    import rbm_vote_classifier_pkg::*;
#(
    parameter int class_num       = 10,
    parameter int num_samples     = 16,
    parameter int count_bitlength = 5,
    parameter int index_bitlength = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       layer_reset,
    output logic                       layer_valid,
    input  logic                       layer_finish,
    input  logic [class_num-1:0]       layer_data,
    output logic                       busy,
    output logic [index_bitlength-1:0] class_out,
    output logic                       class_valid
);

    localparam int SAMPLE_W = (clog2(num_samples) < 1) ? 1 : clog2(num_samples);
    localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(num_samples - 1);

    if (num_samples > (2 ** count_bitlength) - 1) begin : g_bad_count_width
        $error("num_samples does not fit in count_bitlength bits");
    end
    if (clog2(class_num) > index_bitlength) begin : g_bad_index_width
        $error("index_bitlength too small for class_num");
    end

    state_t                               r_state;
    state_t                               w_next;
    logic [SAMPLE_W-1:0]                  r_sample;
    logic [class_num*count_bitlength-1:0] r_counts;
    logic                                 w_scan_start;
    logic                                 w_scan_done;
    logic [index_bitlength-1:0]           w_best_idx;

    always_comb begin
        w_next       = r_state;
        w_scan_start = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_RUN;
            ST_RUN:   if (layer_finish) w_next = ST_ACCUM;
            ST_ACCUM: begin
                if (r_sample == LAST_SAMPLE) begin
                    w_next       = ST_SCAN;
                    w_scan_start = 1'b1;
                end else begin
                    w_next = ST_CLEAR;
                end
            end
            ST_SCAN:  if (w_scan_done) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample    <= '0;
            r_counts    <= '0;
            layer_reset <= 1'b1;
            layer_valid <= 1'b0;
            busy        <= 1'b0;
            class_out   <= '0;
            class_valid <= 1'b0;
        end else begin
            layer_reset <= (w_next == ST_CLEAR);
            layer_valid <= (w_next == ST_RUN);
            busy        <= (w_next != ST_IDLE);
            class_valid <= (w_next == ST_DONE);
            if (w_next == ST_DONE) begin
                class_out <= w_best_idx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sample <= '0;
                        r_counts <= '0;
                    end
                end
                ST_ACCUM: begin
                    for (int i = 0; i < class_num; i++) begin
                        r_counts[i*count_bitlength +: count_bitlength] <=
                            r_counts[i*count_bitlength +: count_bitlength]
                            + count_bitlength'(layer_data[i]);
                    end
                    if (r_sample != LAST_SAMPLE) begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    vote_argmax #(
        .class_num      (class_num),
        .count_bitlength(count_bitlength),
        .index_bitlength(index_bitlength)
    ) u_argmax (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_scan_start),
        .i_counts  (r_counts),
        .o_best_idx(w_best_idx),
        .o_done    (w_scan_done)
    );

endmodule
